// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared widths, RV32I opcodes and immediate-type codes
//
// Purpose: single source of the decode widths, the nine supported RV32I
// opcodes and the immediate-format codes exchanged between imm_gen and
// decode_stage. No ports.

package decode_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int OPCODE_WIDTH   = 7;
    localparam int FUNCT3_WIDTH   = 3;
    localparam int FUNCT7_WIDTH   = 7;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int IMM_TYPE_WIDTH = 3;

    // RV32I base opcodes handled by the core
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;

    // Immediate formats; IMM_NONE covers R-type and unsupported opcodes
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_NONE = 3'd0;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I    = 3'd1;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S    = 3'd2;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_B    = 3'd3;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U    = 3'd4;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J    = 3'd5;

    // Immediate operand replaces rs2 data for every format except B (and none)
    function automatic logic imm_selects_s2(input logic [IMM_TYPE_WIDTH-1:0] t);
        return (t == IMM_I) || (t == IMM_S) || (t == IMM_U) || (t == IMM_J);
    endfunction

endpackage

// File: rtl/decode_stage_imm.sv
// rtl/decode_stage_imm.sv - combinational RV32I immediate generator
//
// Purpose: classify the instruction's immediate format from its opcode and
// build the sign-extended 32-bit immediate.
// Ports:
//   instr_i     in  32  raw instruction word
//   imm_o       out 32  sign-extended immediate (0 for R-type / unsupported)
//   imm_type_o  out 3   immediate format code (IMM_* in decode_stage_pkg)

module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]     instr_i,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic [IMM_TYPE_WIDTH-1:0] imm_type_o
);

    always_comb begin
        imm_type_o = IMM_NONE;
        case (instr_i[OPCODE_WIDTH-1:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type_o = IMM_I;
            OPC_STORE:                      imm_type_o = IMM_S;
            OPC_BRANCH:                     imm_type_o = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_type_o = IMM_U;
            OPC_JAL:                        imm_type_o = IMM_J;
            default:                        imm_type_o = IMM_NONE;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (imm_type_o)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            // B and J immediates are halfword offsets: bit 0 is implicit zero
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I instruction-decode pipeline stage
//
// Purpose: accept one instruction per cycle from fetch, split it into fields,
// gate fields that are meaningless for its format, flag unsupported opcodes
// and hold the result in a single-entry register for execute.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             fetch handshake; in_instr, in_pc payload
//   flush                         squash held and incoming instruction
//   out_valid/out_ready           execute handshake
//   opcode, f3, f7                opcode/funct3/funct7 (gated)
//   rs1_addr, rs2_addr, rd_addr   register indices (gated)
//   imm, use_imm                  immediate and ALU s2 select
//   pc_out, illegal               PC of held instruction, unsupported opcode

module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_instr,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic [FUNCT3_WIDTH-1:0]   f3,
    output logic [FUNCT7_WIDTH-1:0]   f7,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]     imm,
    output logic                      use_imm,
    output logic [DATA_WIDTH-1:0]     pc_out,
    output logic                      illegal
);

    logic                      out_valid_q, out_valid_d;
    logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
    logic [FUNCT3_WIDTH-1:0]   f3_q, f3_d;
    logic [FUNCT7_WIDTH-1:0]   f7_q, f7_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic                      use_imm_q, use_imm_d;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic                      illegal_q, illegal_d;

    logic [DATA_WIDTH-1:0]     gen_imm;
    logic [IMM_TYPE_WIDTH-1:0] gen_imm_type;
    logic                      in_xfer;
    logic                      out_xfer;
    logic                      load_en;

    imm_gen u_imm_gen (
        .instr_i    (in_instr),
        .imm_o      (gen_imm),
        .imm_type_o (gen_imm_type)
    );

    // Single-entry buffer without skid: a new word is taken only when the
    // register is empty or being drained in the same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    // Flush discards the incoming word even though fetch saw it consumed.
    assign load_en  = in_xfer && !flush;

    // Field decode and gating
    always_comb begin
        opcode_d  = in_instr[6:0];
        f3_d      = in_instr[14:12];
        f7_d      = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        illegal_d = 1'b0;
        imm_d     = gen_imm;
        use_imm_d = imm_selects_s2(gen_imm_type);

        case (in_instr[6:0])
            OPC_OP: begin
                rs1_d = in_instr[19:15];
                rs2_d = in_instr[24:20];
                rd_d  = in_instr[11:7];
                f7_d  = in_instr[31:25];
            end
            OPC_OP_IMM: begin
                rs1_d = in_instr[19:15];
                rd_d  = in_instr[11:7];
                // Only shifts carry funct7 (SRAI vs SRLI); for ADDI etc. the
                // upper bits are immediate and must not look like SUB.
                if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
                    f7_d = in_instr[31:25];
                end
            end
            OPC_LOAD, OPC_JALR: begin
                rs1_d = in_instr[19:15];
                rd_d  = in_instr[11:7];
            end
            OPC_STORE, OPC_BRANCH: begin
                rs1_d = in_instr[19:15];
                rs2_d = in_instr[24:20];
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_d = in_instr[11:7];
                f3_d = '0;
            end
            default: begin
                // Still delivered as a valid bundle so execute can trap.
                illegal_d = 1'b1;
                imm_d     = '0;
                use_imm_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_xfer) begin
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            // Data fields hold on drain and flush; only a kept input loads them.
            if (load_en) begin
                opcode_q  <= opcode_d;
                f3_q      <= f3_d;
                f7_q      <= f7_d;
                rs1_q     <= rs1_d;
                rs2_q     <= rs2_d;
                rd_q      <= rd_d;
                imm_q     <= imm_d;
                use_imm_q <= use_imm_d;
                pc_q      <= in_pc;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign f3        = f3_q;
    assign f7        = f7_q;
    assign rs1_addr  = rs1_q;
    assign rs2_addr  = rs2_q;
    assign rd_addr   = rd_q;
    assign imm       = imm_q;
    assign use_imm   = use_imm_q;
    assign pc_out    = pc_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage

module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bundle_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] imm, pc_out;
    logic        use_imm, illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        m_valid;
    bundle_t     m_b;
    bundle_t     act_b;
    logic [31:0] out_log[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .f3(f3), .f7(f7),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .use_imm(use_imm), .pc_out(pc_out), .illegal(illegal)
    );

    assign act_b = {opcode, f3, f7, rs1_addr, rs2_addr, rd_addr, imm, use_imm, illegal, pc_out};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3v, input logic [6:0] f7v,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                                   input logic [31:0] iv, input logic u, input logic il, input logic [31:0] p);
        bundle_t b;
        b = '{op:op, f3:f3v, f7:f7v, rs1:r1, rs2:r2, rd:rdv, imm:iv, use_imm:u, illegal:il, pc:p};
        return b;
    endfunction

    // Reference decode written from the ISA field definitions with arithmetic shifts
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        bundle_t b;
        logic signed [31:0] sw;
        logic [31:0] sh20, sh19, sh11;
        sw   = w;
        sh20 = sw >>> 20;
        sh19 = sw >>> 19;
        sh11 = sw >>> 11;
        b = '0;
        b.op = w[6:0];
        b.pc = p;
        b.f3 = w[14:12];
        case (w[6:0])
            7'h33: begin b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.f7 = w[31:25]; end
            7'h13: begin
                b.rs1 = w[19:15]; b.rd = w[11:7]; b.imm = sh20; b.use_imm = 1;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) b.f7 = w[31:25];
            end
            7'h03, 7'h67: begin b.rs1 = w[19:15]; b.rd = w[11:7]; b.imm = sh20; b.use_imm = 1; end
            7'h23: begin
                b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.use_imm = 1;
                b.imm = (sh20 & ~32'h1F) | 32'(w[11:7]);
            end
            7'h63: begin
                b.rs1 = w[19:15]; b.rs2 = w[24:20];
                b.imm = (sh19 & 32'hFFFFF000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            7'h37, 7'h17: begin b.rd = w[11:7]; b.f3 = 0; b.imm = w & 32'hFFFFF000; b.use_imm = 1; end
            7'h6F: begin
                b.rd = w[11:7]; b.f3 = 0; b.use_imm = 1;
                b.imm = (sh11 & 32'hFFF00000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            default: b.illegal = 1;
        endcase
        return b;
    endfunction

    // One clock of stimulus: check in_ready mid-cycle, advance the model at the
    // edge, then check out_valid and the full bundle just after the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl, input logic r);
        logic exp_rdy;
        in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst = r;
        @(negedge clk);
        exp_rdy = !m_valid || ordy;
        check("in_ready", in_ready, exp_rdy);
        if (!r && out_valid && ordy) out_log.push_back(pc_out);
        if (r) begin
            m_valid = 0; m_b = '0;
        end else if (fl) begin
            m_valid = 0;
        end else if (v && exp_rdy) begin
            m_valid = 1; m_b = ref_decode(ins, p);
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("bundle", act_b, m_b);
    endtask

    vec_t        vecs[9];
    logic [31:0] exp_order[$];
    logic [6:0]  opc_pool[9];

    initial begin
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_b = '0;
        check("reset out_valid", out_valid, 0);
        check("reset bundle", act_b, 0);
        check("reset in_ready", in_ready, 1);

        vecs[0] = '{32'h002081B3, 32'h100, mk(7'h33, 0, 0,    1, 2, 3, 32'h0,        0, 0, 32'h100)};
        vecs[1] = '{32'hFFF00093, 32'h104, mk(7'h13, 0, 0,    0, 0, 1, 32'hFFFFFFFF, 1, 0, 32'h104)};
        vecs[2] = '{32'h4032D293, 32'h108, mk(7'h13, 5, 7'h20, 5, 0, 5, 32'h00000403, 1, 0, 32'h108)};
        vecs[3] = '{32'h0020A423, 32'h10C, mk(7'h23, 2, 0,    1, 2, 0, 32'h8,        1, 0, 32'h10C)};
        vecs[4] = '{32'hFE000EE3, 32'h110, mk(7'h63, 0, 0,    0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h110)};
        vecs[5] = '{32'h00000000, 32'h114, mk(7'h00, 0, 0,    0, 0, 0, 32'h0,        0, 1, 32'h114)};
        vecs[6] = '{32'h0000007F, 32'h118, mk(7'h7F, 0, 0,    0, 0, 0, 32'h0,        0, 1, 32'h118)};
        vecs[7] = '{32'h123452B7, 32'h11C, mk(7'h37, 0, 0,    0, 0, 5, 32'h12345000, 1, 0, 32'h11C)};
        vecs[8] = '{32'h008000EF, 32'h120, mk(7'h6F, 0, 0,    0, 0, 1, 32'h8,        1, 0, 32'h120)};

        // Back-to-back table vectors, each checked against its constant record
        for (int i = 0; i < 9; i++) begin
            step(1, vecs[i].instr, vecs[i].pc, 1, 0, 0);
            check($sformatf("vec%0d valid", i), out_valid, 1);
            check($sformatf("vec%0d bundle", i), act_b, vecs[i].exp);
        end
        step(0, 0, 0, 1, 0, 0);

        // Backpressure mid-stream: 4 instructions, out_ready low for 3 cycles
        out_log.delete();
        step(1, 32'h00100093, 32'h200, 1, 0, 0);
        step(1, 32'h00208113, 32'h204, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h00310193, 32'h208, 0, 0, 0);
            check("stall pc held", pc_out, 32'h204);
            check("stall in_ready", in_ready, 0);
        end
        step(1, 32'h00310193, 32'h208, 1, 0, 0);
        step(1, 32'h00418213, 32'h20C, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        exp_order = '{32'h200, 32'h204, 32'h208, 32'h20C};
        check("order count", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            check($sformatf("order %0d", k), out_log[k], exp_order[k]);

        // Flush with held bundle and incoming word in the same cycle
        out_log.delete();
        step(1, 32'h00500293, 32'h300, 0, 0, 0);
        step(1, 32'h00600313, 32'h304, 1, 1, 0);
        check("flush out_valid", out_valid, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("flushed word absent", (out_log.size() == 1) && (out_log[0] == 32'h300), 1);

        // Reset mid-stream with a held bundle; reset overrides flush
        step(1, 32'h00700393, 32'h400, 0, 0, 0);
        step(1, 32'h00800413, 32'h404, 0, 0, 0);
        step(1, 32'h00900493, 32'h408, 1, 1, 1);
        check("rst out_valid", out_valid, 0);
        check("rst pc_out", pc_out, 0);
        check("rst bundle zero", act_b, 0);

        // Randomized traffic against the reference model
        opc_pool = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = opc_pool[$urandom_range(0, 8)];
            step($urandom_range(0, 9) < 7, w, $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
